ahb_bus_arbiter: RTL
====================

Name: ahb_bus_arbiter

Overview:
Round-robin arbiter that shares one AHB address/data path between NUM_MASTERS bus masters.
- Produces one-hot hgrant, the hmaster index that drives the address/data muxes, and hmastlock.
- Sits between the masters and the shared interconnect in the AHB socket, alongside the decoder and slave mux.
- Enforces a per-tenure beat limit for fairness, bypassed for locked transfers.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
MIDX_W, 2, width of hmaster; must equal clog2(NUM_MASTERS)
DEFAULT_MASTER, 0, master parked on the bus when nobody requests
MAX_HOLD, 4, maximum active beats per tenure before forced re-arbitration (1..255)

Ports:
hclk  in  1  bus clock, all logic on rising edge
hrst  in  1  synchronous active-high reset
hbusreq  in  NUM_MASTERS  per-master bus request
hlock  in  NUM_MASTERS  per-master locked-transfer request
htrans  in  2  transfer type of the muxed bus (current owner)
hready  in  1  muxed slave ready
hgrant  out  NUM_MASTERS  one-hot grant, registered
hmaster  out  MIDX_W  index of the master owning the address phase, registered
hmastlock  out  1  current address phase is locked, registered

Behaviour:
- Reset (hrst=1 at edge):
  - hgrant = 1<<DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0.
  - hold_cnt = 0; state = PARK; rr_ptr = DEFAULT_MASTER.
  - Reset mid-transfer abandons the tenure with no completion.
- State machine: PARK, GRANT, LOCKED. It advances only on edges with hready=1; with hready=0 all registers hold.
- Active beat: hready=1 and htrans is NONSEQ(10) or SEQ(11) while owner = hmaster. Each active beat increments hold_cnt, saturating at MAX_HOLD.
- Arbitration edge: hready=1 and any of:
  - state PARK;
  - state GRANT and hbusreq[granted]=0;
  - state GRANT and hold_cnt==MAX_HOLD.
  LOCKED never re-arbitrates while hlock[granted]=1.
- Selection at an arbitration edge:
  - Scan hbusreq starting at rr_ptr+1, wrapping modulo NUM_MASTERS; first set bit wins.
  - The currently granted master is scanned last, so it is re-granted only if it is the sole requester.
  - No requester: grant DEFAULT_MASTER, go to PARK.
  - Winner found: hgrant <= one-hot(winner); rr_ptr <= winner; hold_cnt <= 0.
  - Next state is LOCKED if hlock[winner]=1, else GRANT.
- LOCKED → GRANT when hlock[granted] falls (hready=1); hold_cnt continues from its current value.
- Handover: on every edge with hready=1, hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)]. hmaster therefore lags hgrant by one hready-qualified cycle, matching the AHB address-phase handover.
- Latency: request sampled at an arbitration edge → hgrant next cycle; hmaster on the next hready-high edge. Minimum is 2 cycles from request to hmaster.
- Grant removal mid-burst is legal. The master restarts with NONSEQ; the arbiter does not track hburst.
- Simultaneous requests: decided purely by rotating priority, no fixed-priority bias.
- hgrant is always exactly one-hot, including directly after reset.
- hmaster never takes a value ≥ NUM_MASTERS.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11;
  - arbiter state encoding PARK/GRANT/LOCKED;
  - onehot-to-index helper function.
- One sub-module, ahb_rr_picker: combinational rotating-priority selector. Inputs are req vector, pointer and current-owner mask; outputs are one-hot winner and a valid flag.
- State machine, hold counter and output registers stay in ahb_bus_arbiter.

Test Plan:
1. Reset, no requests, hready=1 → hgrant=4'b0001, hmaster=0, hmastlock=0, held for 20 cycles.
2. hbusreq=4'b0100 from cycle 5 → hgrant=4'b0100 at cycle 6, hmaster=2 at cycle 7. Drop req at cycle 12 → hgrant=4'b0001 at cycle 13 (park).
3. hbusreq=4'b1111 constantly, htrans=SEQ, hready=1 → grant order 1,2,3,0,1; each tenure exactly MAX_HOLD=4 active beats.
4. Master 3 granted with hlock[3]=1, others requesting, 10 SEQ beats → hgrant stays 4'b1000, hmastlock=1. Deassert hlock → re-arbitration once hold_cnt==4.
5. hready=0 for 3 cycles while hbusreq changes from 4'b0010 to 4'b1000 → hgrant and hmaster frozen. Both update only after hready returns to 1.
6. hrst asserted mid-tenure with master 2 granted → next cycle hgrant=4'b0001, hmaster=0, hmastlock=0, hold_cnt=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer codes, arbiter states and one-hot helper
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {PARK, GRANT, LOCKED} arb_state_e;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) idx = oh[i] ? (idx | 3'(i)) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: rotating-priority selector that considers the current owner last
module ahb_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] owner,
  output logic [N-1:0] win,
  output logic         valid
);
  logic [N-1:0] others;
  function automatic logic [W-1:0] wrap(input int v);
    return W'(v % N);
  endfunction
  // descending scan so the nearest requester after ptr overwrites farther ones
  always_comb begin
    others = req & ~owner;
    win = '0;
    for (int k = N; k >= 1; k--) win = others[wrap(int'(ptr) + k)] ? (N'(1) << wrap(int'(ptr) + k)) : win;
    win = (others == '0) ? (req & owner) : win;
    valid = |req;
  end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with tenure beat limit and lock support
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MIDX_W         = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 4
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MIDX_W-1:0]      hmaster,
  output logic                   hmastlock
);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MIDX_W-1:0] DEF_IDX = MIDX_W'(DEFAULT_MASTER);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  arb_state_e state, state_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic [MIDX_W-1:0] rr_ptr, rr_nx, gidx, pidx;
  logic [NUM_MASTERS-1:0] pick, grant_nx;
  logic pick_valid, active, arb;
  ahb_rr_picker #(.N(NUM_MASTERS), .W(MIDX_W)) u_picker (
    .req(hbusreq),
    .ptr(rr_ptr),
    .owner(hgrant),
    .win(pick),
    .valid(pick_valid)
  );
  // next-state, grant, hold counter and pointer; everything freezes while hready is low
  always_comb begin
    gidx = MIDX_W'(oh2idx(8'(hgrant)));
    pidx = MIDX_W'(oh2idx(8'(pick)));
    active = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    arb = hready && (state == PARK || (state == GRANT && (!hbusreq[gidx] || hold_cnt == HOLD_MAX)));
    grant_nx = arb ? (pick_valid ? pick : DEF_OH) : hgrant;
    rr_nx = (arb && pick_valid) ? pidx : rr_ptr;
    hold_nx = arb ? 8'd0 : (active && hold_cnt != HOLD_MAX) ? hold_cnt + 8'd1 : hold_cnt;
    state_nx = arb ? (pick_valid ? (hlock[pidx] ? LOCKED : GRANT) : PARK)
             : (hready && state == LOCKED && !hlock[gidx]) ? GRANT : state;
  end
  // state and output registers; hmaster follows hgrant one ready cycle later
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state <= PARK;
      hgrant <= DEF_OH;
      hold_cnt <= '0;
      rr_ptr <= DEF_IDX;
      hmaster <= DEF_IDX;
      hmastlock <= 1'b0;
    end else begin
      state <= state_nx;
      hgrant <= grant_nx;
      hold_cnt <= hold_nx;
      rr_ptr <= rr_nx;
      if (hready) begin
        hmaster <= gidx;
        hmastlock <= hlock[gidx];
      end
    end
  end
endmodule
